sys_bus_arbiter: RTL

SYS_BUS_ARBITER -- requirements
Module: sys_bus_arbiter

---
 rtl/sys_bus_pkg.sv | 20 ++
 rtl/sys_bus_arbiter.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/sys_bus_pkg.sv
// -----------------------------------------------------------------------------
// sys_bus_pkg
// Shared definitions for the two-master system bus arbiter:
//   bus_state_t    - arbiter FSM encoding (IDLE / BUSY)
//   TIMEOUT_RDATA  - read data returned to a master whose slave never answered
//   M0, M1         - master index constants, used as grant / last-served values
// -----------------------------------------------------------------------------
package sys_bus_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } bus_state_t;

  localparam logic [31:0] TIMEOUT_RDATA = 32'hDEADBEEF;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

endpackage

// File: rtl/sys_bus_arbiter.sv
// -----------------------------------------------------------------------------
// sys_bus_arbiter
// Round-robin arbiter giving two masters (m0, m1) access to one slave port that
// feeds the address decoder. One transaction at a time, no preemption.
//
// Optional feature: define SYS_BUS_TIMEOUT_EN to add a slave-response watchdog
// that completes a stalled transaction with TIMEOUT_RDATA after
// TIMEOUT_CYCLES BUSY cycles. Without the macro BUSY waits indefinitely and
// bus_timeout is tied low.
//
// Parameters
//   TIMEOUT_CYCLES  slave-response limit in BUSY cycles (2..65535)
// Ports
//   clk, rst                      clock (rising edge), async active-high reset
//   mN_valid/addr/wdata/wstrb     master request (wstrb == 0 means read)
//   mN_ready/rdata                master completion pulse and read data
//   s_valid/addr/wdata/wstrb      request forwarded to the address decoder
//   s_ready/rdata                 muxed slave response
//   grant                         current / most recent owner (0 = m0, 1 = m1)
//   bus_timeout                   one-cycle pulse when the watchdog fires
//   dbg_state                     arbiter FSM state, for observation only
//
// Handshake: a master raises mN_valid with stable addr/wdata/wstrb and holds it
// until mN_ready is seen high for one cycle; that cycle is the completion.
// Toward the slave, s_valid is held while the owner waits, and the transfer
// completes in the cycle s_ready is high while s_valid is high.
// -----------------------------------------------------------------------------
module sys_bus_arbiter
  import sys_bus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_valid,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,
  output logic        s_valid,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic        s_ready,
  input  logic [31:0] s_rdata,
  output logic        grant,
  output logic        bus_timeout,
  output bus_state_t  dbg_state
);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("sys_bus_arbiter: TIMEOUT_CYCLES must be within 2..65535");
  end

  bus_state_t  state_q, state_d;
  logic        grant_q, grant_d;
  logic        last_q, last_d;     // master served by the last completed transfer

  logic        busy;
  logic        owner_valid;
  logic        pick;
  logic        complete;
  logic        to_hit;
  logic        finish;
  logic [31:0] resp_data;

  assign busy        = (state_q == ST_BUSY);
  assign owner_valid = (grant_q == M1) ? m1_valid : m0_valid;

  // Round-robin: on contention the master not served last wins.
  always_comb begin
    if (m0_valid && m1_valid) begin
      pick = ~last_q;
    end else if (m1_valid) begin
      pick = M1;
    end else begin
      pick = M0;
    end
  end

`ifdef SYS_BUS_TIMEOUT_EN
  logic [15:0] cnt_q;

  // Counter reads 0 in the first BUSY cycle, so it equals TIMEOUT_CYCLES-1 in
  // the TIMEOUT_CYCLES-th BUSY cycle. s_ready in that cycle still wins.
  assign to_hit = busy && owner_valid && !s_ready &&
                  (cnt_q == 16'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (!busy) begin
      cnt_q <= '0;
    end else if (!s_ready) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end
`else
  assign to_hit = 1'b0;
`endif

  assign complete = busy && owner_valid && s_ready;
  assign finish   = complete || to_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      grant_q <= M0;
      last_q  <= M1;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        if (m0_valid || m1_valid) begin
          grant_d = pick;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (!owner_valid) begin
          // Owner withdrew its request: abandon it without touching fairness.
          state_d = ST_IDLE;
        end else if (finish) begin
          state_d = ST_IDLE;
          last_d  = grant_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Request path: owner's fields pass straight through; only s_valid is gated.
  assign s_valid = busy && owner_valid && !to_hit;
  assign s_addr  = (grant_q == M1) ? m1_addr  : m0_addr;
  assign s_wdata = (grant_q == M1) ? m1_wdata : m0_wdata;
  assign s_wstrb = (grant_q == M1) ? m1_wstrb : m0_wstrb;

  // Response path: rdata is zero whenever the matching ready is low.
  assign resp_data = complete ? s_rdata : TIMEOUT_RDATA;
  assign m0_ready  = finish && (grant_q == M0);
  assign m1_ready  = finish && (grant_q == M1);
  assign m0_rdata  = m0_ready ? resp_data : 32'h0;
  assign m1_rdata  = m1_ready ? resp_data : 32'h0;

  assign grant       = grant_q;
  assign bus_timeout = to_hit;
  assign dbg_state   = state_q;

endmodule
